// File: rtl/uart_reg_bridge_pkg.sv
// Frame constants, status codes and FSM state type shared by the UART register bridge.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package uart_reg_bridge_pkg;

    localparam logic [7:0] SOF_REQ = 8'h12;
    localparam logic [7:0] SOF_RSP = 8'hA5;
    localparam logic [7:0] CMD_RD  = 8'h34;
    localparam logic [7:0] CMD_WR  = 8'h56;

    localparam logic [7:0] ST_OK     = 8'h00;
    localparam logic [7:0] ST_RANGE  = 8'hE1;
    localparam logic [7:0] ST_BADCMD = 8'hE2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_EXEC,
        S_TX
    } state_t;

    // 16x oversampling divisor; never below 1 so the tick generator keeps running.
    function automatic int baud_divisor(input int clk_freq, input int baud);
        int d;
        d = clk_freq / baud / 16;
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_transceiver.sv
// 8N1 UART transceiver with 16x oversampled receiver and a byte-wide transmitter.
// Latency: rx_done pulses at mid-stop-bit; tx_done pulses at the end of the stop bit.
// Backpressure: none; tx_wr must only be pulsed while idle, received bytes are not buffered.
module uart_transceiver (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        uart_rx,
    output logic        uart_tx,
    input  logic [15:0] divisor,
    output logic [7:0]  rx_data,
    output logic        rx_done,
    input  logic [7:0]  tx_data,
    input  logic        tx_wr,
    output logic        tx_done
);

    logic [15:0] enable_cnt;
    logic        enable16;
    logic        rx_s1;
    logic        rx_s2;
    logic        rx_busy;
    logic [3:0]  rx_cnt16;
    logic [3:0]  rx_bitcnt;
    logic [7:0]  rx_reg;
    logic        tx_busy;
    logic [3:0]  tx_cnt16;
    logic [3:0]  tx_bitcnt;
    logic [8:0]  tx_reg;

    assign enable16 = (enable_cnt == 16'd0);

    // Oversampling tick: one enable16 every 'divisor' clocks.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            enable_cnt <= 16'd0;
        end else if (enable16) begin
            enable_cnt <= divisor - 16'd1;
        end else begin
            enable_cnt <= enable_cnt - 16'd1;
        end
    end

    // Two-flop synchroniser on the asynchronous serial input.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= uart_rx;
            rx_s2 <= rx_s1;
        end
    end

    // Receiver: detect start, sample each bit mid-period, accept the byte only with a valid stop bit.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rx_busy   <= 1'b0;
            rx_cnt16  <= 4'd0;
            rx_bitcnt <= 4'd0;
            rx_reg    <= 8'h00;
            rx_data   <= 8'h00;
            rx_done   <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            if (enable16) begin
                if (!rx_busy) begin
                    if (!rx_s2) begin
                        rx_busy   <= 1'b1;
                        rx_cnt16  <= 4'd0;
                        rx_bitcnt <= 4'd0;
                    end
                end else begin
                    rx_cnt16 <= rx_cnt16 + 4'd1;
                    if (rx_cnt16 == 4'd7) begin
                        rx_bitcnt <= rx_bitcnt + 4'd1;
                        if (rx_bitcnt == 4'd0) begin
                            // glitch shorter than half a bit: not a real start bit
                            if (rx_s2) begin
                                rx_busy <= 1'b0;
                            end
                        end else if (rx_bitcnt == 4'd9) begin
                            rx_busy <= 1'b0;
                            if (rx_s2) begin
                                rx_data <= rx_reg;
                                rx_done <= 1'b1;
                            end
                        end else begin
                            rx_reg <= {rx_s2, rx_reg[7:1]};
                        end
                    end
                end
            end
        end
    end

    // Transmitter: start bit on tx_wr, then 8 data bits LSB first and one stop bit.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            uart_tx   <= 1'b1;
            tx_busy   <= 1'b0;
            tx_reg    <= 9'h1FF;
            tx_cnt16  <= 4'd0;
            tx_bitcnt <= 4'd0;
            tx_done   <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (tx_wr) begin
                uart_tx   <= 1'b0;
                tx_reg    <= {1'b1, tx_data};
                tx_busy   <= 1'b1;
                tx_cnt16  <= 4'd0;
                tx_bitcnt <= 4'd0;
            end else if (enable16 && tx_busy) begin
                tx_cnt16 <= tx_cnt16 + 4'd1;
                if (tx_cnt16 == 4'd15) begin
                    if (tx_bitcnt == 4'd9) begin
                        tx_busy <= 1'b0;
                        tx_done <= 1'b1;
                    end else begin
                        uart_tx   <= tx_reg[0];
                        tx_reg    <= {1'b1, tx_reg[8:1]};
                        tx_bitcnt <= tx_bitcnt + 4'd1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/uart_reg_bridge.sv
// UART command bridge: parses read/write frames, executes them on a register bank, returns checksummed response.
// Latency: EXEC is one cycle after the last request byte; first response byte is launched the cycle after EXEC.
// Backpressure: none on the line; bytes arriving during EXEC/TX are dropped, stalled frames abort on timeout.
module uart_reg_bridge
    import uart_reg_bridge_pkg::*;
#(
    parameter int CLK_FREQ       = 100000000,
    parameter int BAUD           = 115200,
    parameter int ADDR_BYTES     = 1,
    parameter int DATA_BYTES     = 4,
    parameter int NUM_REGS       = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               uart_rx,
    output logic                               uart_tx,
    output logic [NUM_REGS*8*DATA_BYTES-1:0]   regs_out,
    output logic                               wr_stb,
    output logic [8*ADDR_BYTES-1:0]            wr_addr,
    output logic                               busy
);

    localparam int          AW        = 8 * ADDR_BYTES;
    localparam int          DW        = 8 * DATA_BYTES;
    localparam int          RSP_BYTES = 2 + DATA_BYTES;
    localparam int          RSPW      = 8 * RSP_BYTES;
    localparam logic [15:0] DIVISOR   = 16'(baud_divisor(CLK_FREQ, BAUD));
    localparam logic [31:0] TMO_LIMIT = 32'(TIMEOUT_CYCLES);

    state_t                 state;
    logic                   is_wr;
    logic [7:0]             status;
    logic [AW-1:0]          addr_sr;
    logic [DW-1:0]          data_sr;
    logic [2:0]             byte_cnt;
    logic [31:0]            tmo_cnt;
    logic [RSPW-1:0]        rsp_sr;
    logic [2:0]             tx_left;
    logic [NUM_REGS*DW-1:0] regs_q;

    logic                   rx_done;
    logic [7:0]             rx_data;
    logic                   tx_wr;
    logic [7:0]             tx_data;
    logic                   tx_done;

    logic [31:0]            addr_ext;
    logic                   addr_ok;
    logic [DW-1:0]          rd_data;
    logic [7:0]             exec_status;
    logic [DW-1:0]          exec_data;
    logic [7:0]             exec_chk;

    uart_transceiver u_xcvr (
        .sys_clk (clk),
        .sys_rst (rst),
        .uart_rx (uart_rx),
        .uart_tx (uart_tx),
        .divisor (DIVISOR),
        .rx_data (rx_data),
        .rx_done (rx_done),
        .tx_data (tx_data),
        .tx_wr   (tx_wr),
        .tx_done (tx_done)
    );

    assign regs_out = regs_q;
    assign busy     = (state != S_IDLE);
    assign addr_ext = 32'(addr_sr);
    assign addr_ok  = (addr_ext < 32'(NUM_REGS));

    // Read mux over the flat bank; yields 0 for out-of-range addresses.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr_ext == 32'(i)) begin
                rd_data = regs_q[i*DW +: DW];
            end
        end
    end

    // Response contents for EXEC: bad command beats range error beats normal result.
    always_comb begin
        exec_status = ST_OK;
        exec_data   = '0;
        if (status == ST_BADCMD) begin
            exec_status = ST_BADCMD;
        end else if (!addr_ok) begin
            exec_status = ST_RANGE;
        end else if (is_wr) begin
            exec_data = data_sr;
        end else begin
            exec_data = rd_data;
        end
        exec_chk = exec_status;
        for (int b = 0; b < DATA_BYTES; b++) begin
            exec_chk = exec_chk ^ exec_data[b*8 +: 8];
        end
    end

    // Frame FSM: parse request, execute once, stream the response, with inter-byte timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            is_wr    <= 1'b0;
            status   <= ST_OK;
            addr_sr  <= '0;
            data_sr  <= '0;
            byte_cnt <= 3'd0;
            tmo_cnt  <= 32'd0;
            rsp_sr   <= '0;
            tx_left  <= 3'd0;
            tx_wr    <= 1'b0;
            tx_data  <= 8'h00;
            regs_q   <= '0;
            wr_stb   <= 1'b0;
            wr_addr  <= '0;
        end else begin
            tx_wr  <= 1'b0;
            wr_stb <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rx_done && rx_data == SOF_REQ) begin
                        state    <= S_CMD;
                        is_wr    <= 1'b0;
                        status   <= ST_OK;
                        addr_sr  <= '0;
                        data_sr  <= '0;
                        byte_cnt <= 3'd0;
                        tmo_cnt  <= 32'd0;
                    end
                end
                S_CMD: begin
                    if (rx_done) begin
                        tmo_cnt <= 32'd0;
                        if (rx_data == CMD_RD) begin
                            is_wr <= 1'b0;
                            state <= S_ADDR;
                        end else if (rx_data == CMD_WR) begin
                            is_wr <= 1'b1;
                            state <= S_ADDR;
                        end else begin
                            status <= ST_BADCMD;
                            state  <= S_EXEC;
                        end
                    end else if (tmo_cnt >= TMO_LIMIT) begin
                        state <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                end
                S_ADDR: begin
                    if (rx_done) begin
                        tmo_cnt <= 32'd0;
                        addr_sr <= AW'({addr_sr, rx_data});
                        if (byte_cnt == 3'(ADDR_BYTES - 1)) begin
                            byte_cnt <= 3'd0;
                            state    <= is_wr ? S_DATA : S_EXEC;
                        end else begin
                            byte_cnt <= byte_cnt + 3'd1;
                        end
                    end else if (tmo_cnt >= TMO_LIMIT) begin
                        state <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                end
                S_DATA: begin
                    if (rx_done) begin
                        tmo_cnt <= 32'd0;
                        data_sr <= DW'({data_sr, rx_data});
                        if (byte_cnt == 3'(DATA_BYTES - 1)) begin
                            byte_cnt <= 3'd0;
                            state    <= S_EXEC;
                        end else begin
                            byte_cnt <= byte_cnt + 3'd1;
                        end
                    end else if (tmo_cnt >= TMO_LIMIT) begin
                        state <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                end
                S_EXEC: begin
                    rsp_sr  <= {exec_status, exec_data, exec_chk};
                    tx_data <= SOF_RSP;
                    tx_wr   <= 1'b1;
                    tx_left <= 3'(RSP_BYTES);
                    if (exec_status == ST_OK && is_wr) begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (addr_ext == 32'(i)) begin
                                regs_q[i*DW +: DW] <= data_sr;
                            end
                        end
                        wr_stb  <= 1'b1;
                        wr_addr <= addr_sr;
                    end
                    state <= S_TX;
                end
                S_TX: begin
                    if (tx_done) begin
                        if (tx_left == 3'd0) begin
                            state <= S_IDLE;
                        end else begin
                            tx_data <= rsp_sr[RSPW-1 -: 8];
                            rsp_sr  <= {rsp_sr[RSPW-9:0], 8'h00};
                            tx_left <= tx_left - 3'd1;
                            tx_wr   <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Directed bench for uart_reg_bridge: serial request driver, serial response monitor, frame-level model.
// Latency: responses are awaited with bounded cycle budgets.
// Backpressure: requests are sent back-to-back only after the previous response has completed.
module tb_uart_reg_bridge;

    localparam int TMO = 400;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         uart_rx = 1'b1;
    logic         uart_tx;
    logic [511:0] regs_out;
    logic         wr_stb;
    logic [7:0]   wr_addr;
    logic         busy;

    int           n_chk = 0;
    int           n_fail = 0;
    logic [31:0]  mregs [16];
    logic [7:0]   req_q [$];
    logic [7:0]   lit_q [$];
    logic [7:0]   exp_q [$];
    logic [7:0]   rsp_q [$];
    bit           chk_en = 1'b0;
    int           wr_cnt = 0;
    logic [7:0]   last_waddr = 8'h00;
    bit           exp_wr = 1'b0;
    logic [7:0]   exp_waddr = 8'h00;

    always #5 clk = ~clk;

    uart_reg_bridge #(
        .CLK_FREQ       (16),
        .BAUD           (1),
        .ADDR_BYTES     (1),
        .DATA_BYTES     (4),
        .NUM_REGS       (16),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .uart_rx  (uart_rx),
        .uart_tx  (uart_tx),
        .regs_out (regs_out),
        .wr_stb   (wr_stb),
        .wr_addr  (wr_addr),
        .busy     (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] model_flat();
        logic [511:0] f;
        for (int i = 0; i < 16; i++) f[i*32 +: 32] = mregs[i];
        return f;
    endfunction

    // Continuous compare: register bank against model, line idles high whenever not busy.
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            n_chk++;
            if (regs_out !== model_flat()) begin
                n_fail++;
                $display("FAIL regs_out: got %h expected %h", regs_out, model_flat());
            end
            if (busy === 1'b0) begin
                n_chk++;
                if (uart_tx !== 1'b1) begin
                    n_fail++;
                    $display("FAIL idle_line: got uart_tx=%b expected 1", uart_tx);
                end
            end
        end
        if (wr_stb === 1'b1) begin
            wr_cnt++;
            last_waddr = wr_addr;
        end
    end

    // Serial monitor: decodes response bytes, discards any byte interrupted by reset.
    initial begin : monitor
        logic [7:0] b;
        bit         ab;
        bit         stop;
        forever begin
            @(negedge clk);
            if (!rst && uart_tx === 1'b0) begin
                ab = 1'b0;
                for (int k = 0; k < 7; k++) begin
                    @(negedge clk);
                    if (rst) ab = 1'b1;
                end
                for (int bit_i = 0; bit_i < 8; bit_i++) begin
                    for (int k = 0; k < 16; k++) begin
                        @(negedge clk);
                        if (rst) ab = 1'b1;
                    end
                    b[bit_i] = uart_tx;
                end
                for (int k = 0; k < 16; k++) begin
                    @(negedge clk);
                    if (rst) ab = 1'b1;
                end
                stop = uart_tx;
                if (!ab && stop) rsp_q.push_back(b);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (16) @(negedge clk);
        end
        uart_rx = 1'b1;
        repeat (16) @(negedge clk);
    endtask

    // Frame-level model: decides the response and register effect from the request bytes alone.
    task automatic model_exec();
        logic [7:0]  st;
        logic [31:0] d;
        logic [7:0]  a;
        exp_q.delete();
        exp_wr = 1'b0;
        d = 32'h0;
        if (req_q[1] != 8'h34 && req_q[1] != 8'h56) begin
            st = 8'hE2;
        end else begin
            a = req_q[2];
            if (a >= 8'd16) begin
                st = 8'hE1;
            end else begin
                st = 8'h00;
                if (req_q[1] == 8'h56) begin
                    d = {req_q[3], req_q[4], req_q[5], req_q[6]};
                    mregs[a[3:0]] = d;
                    exp_wr = 1'b1;
                    exp_waddr = a;
                end else begin
                    d = mregs[a[3:0]];
                end
            end
        end
        exp_q.push_back(8'hA5);
        exp_q.push_back(st);
        exp_q.push_back(d[31:24]);
        exp_q.push_back(d[23:16]);
        exp_q.push_back(d[15:8]);
        exp_q.push_back(d[7:0]);
        exp_q.push_back(st ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0]);
    endtask

    task automatic run_frame(input string name, input bit expect_rsp);
        chk_en = 1'b0;
        wr_cnt = 0;
        exp_wr = 1'b0;
        rsp_q.delete();
        foreach (req_q[i]) send_byte(req_q[i]);
        if (expect_rsp) model_exec();
        chk_en = 1'b1;
        if (expect_rsp) begin
            check($sformatf("%s model_len", name), exp_q.size(), lit_q.size());
            foreach (lit_q[i]) begin
                if (i < exp_q.size()) check($sformatf("%s model_byte%0d", name, i), exp_q[i], lit_q[i]);
            end
            for (int c = 0; c < 3000 && rsp_q.size() < exp_q.size(); c++) @(negedge clk);
            check($sformatf("%s rsp_len", name), rsp_q.size(), exp_q.size());
            foreach (exp_q[i]) begin
                if (i < rsp_q.size()) check($sformatf("%s rsp_byte%0d", name, i), rsp_q[i], exp_q[i]);
            end
        end else begin
            repeat (TMO + 200) @(negedge clk);
            check($sformatf("%s no_rsp", name), rsp_q.size(), 0);
        end
        repeat (30) @(negedge clk);
        check($sformatf("%s busy_idle", name), busy, 0);
        check($sformatf("%s wr_count", name), wr_cnt, exp_wr);
        if (exp_wr) check($sformatf("%s wr_addr", name), last_waddr, exp_waddr);
    endtask

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

    initial begin : stim
        for (int i = 0; i < 16; i++) mregs[i] = 32'h0;
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("reset uart_tx", uart_tx, 1);
        check("reset busy", busy, 0);
        check("reset wr_stb", wr_stb, 0);
        check("reset wr_addr", wr_addr, 0);
        check("reset regs_zero", 32'(regs_out != '0), 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        req_q = '{8'h12, 8'h56, 8'h03, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        lit_q = '{8'hA5, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
        run_frame("write", 1'b1);
        check("write reg3", regs_out[3*32 +: 32], 32'hDEADBEEF);

        req_q = '{8'h12, 8'h34, 8'h03};
        run_frame("read", 1'b1);

        req_q = '{8'h12, 8'h56, 8'h20, 8'h11, 8'h22, 8'h33, 8'h44};
        lit_q = '{8'hA5, 8'hE1, 8'h00, 8'h00, 8'h00, 8'h00, 8'hE1};
        run_frame("range", 1'b1);

        req_q = '{8'h12, 8'h77};
        lit_q = '{8'hA5, 8'hE2, 8'h00, 8'h00, 8'h00, 8'h00, 8'hE2};
        run_frame("badcmd", 1'b1);

        req_q = '{8'h12, 8'h34, 8'h03};
        lit_q = '{8'hA5, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
        run_frame("read_after_bad", 1'b1);

        req_q = '{8'h12, 8'h56, 8'h05, 8'hAA};
        run_frame("timeout", 1'b0);
        check("timeout reg5", regs_out[5*32 +: 32], 32'h0);

        req_q = '{8'h12, 8'h34, 8'h05};
        lit_q = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_frame("read_reg5", 1'b1);

        // Reset during the third response byte.
        chk_en = 1'b0;
        rsp_q.delete();
        req_q = '{8'h12, 8'h34, 8'h03};
        foreach (req_q[i]) send_byte(req_q[i]);
        for (int c = 0; c < 2000 && rsp_q.size() < 2; c++) @(negedge clk);
        check("midrst two_bytes_seen", 32'(rsp_q.size() >= 2), 1);
        for (int c = 0; c < 200 && uart_tx !== 1'b0; c++) @(negedge clk);
        check("midrst third_start", uart_tx, 0);
        repeat (40) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 16; i++) mregs[i] = 32'h0;
        @(negedge clk);
        check("midrst uart_tx", uart_tx, 1);
        check("midrst busy", busy, 0);
        check("midrst regs_zero", 32'(regs_out != '0), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (300) @(negedge clk);
        rsp_q.delete();

        req_q = '{8'h12, 8'h34, 8'h03};
        lit_q = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_frame("read_after_rst", 1'b1);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
